sign_packer: RTL and testbench

Streaming narrowing packer: the inverse of the 2-bit to 8-bit sign extension used on the immediate path. It accepts 8-bit two's-complement samples over a valid/ready handshake and saturates each one to a 2-bit signed field in the range −2..+1. It packs four fields into one 8-bit word and presents that word on a one-deep registered output with its own valid/ready handshake. It sits between the datapath result bus and the compact 2-bit operand store, which holds narrowed values for later re-extension.

---
 rtl/sign_packer.sv | 117 +++++++++++
 tb/tb_sign_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sign_packer.sv
// Narrows 8-bit signed samples to saturated 2-bit fields and packs four per word
// into a one-deep registered output. A partial word can be flushed out early.
module sign_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [3:0] out_sat,
  output logic [2:0] out_count,
  input  logic       out_ready
);

  logic [1:0] cnt_q, cnt_d;
  logic [7:0] acc_data_q, acc_data_d;
  logic [3:0] acc_sat_q, acc_sat_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [3:0] out_sat_q, out_sat_d;
  logic [2:0] out_count_q, out_count_d;

  logic signed [7:0] in_s;
  logic [1:0] field;
  logic       field_sat;
  logic       slot_free;
  logic       accept;
  logic [7:0] merged_data;
  logic [3:0] merged_sat;
  logic [2:0] total;
  logic       word_full;
  logic       flush_ok;

  assign in_s      = in_data;
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (cnt_q != 2'd3) || slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    field     = in_data[1:0];
    field_sat = 1'b0;
    if (in_s > 8'sd1) begin
      field     = 2'b01;
      field_sat = 1'b1;
    end else if (in_s < -8'sd2) begin
      field     = 2'b10;
      field_sat = 1'b1;
    end
  end

  // Merged view includes this cycle's sample so a flush in the same cycle emits it.
  always_comb begin
    merged_data = acc_data_q;
    merged_sat  = acc_sat_q;
    if (accept) begin
      merged_data[{cnt_q, 1'b0} +: 2] = field;
      merged_sat[cnt_q]               = field_sat;
    end
    total     = {1'b0, cnt_q} + {2'b00, accept};
    word_full = accept && (cnt_q == 2'd3);
    flush_ok  = flush && slot_free && !word_full && (total != 3'd0);
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_sat_d   = acc_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    if (word_full || flush_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = merged_data;
      out_sat_d   = merged_sat;
      out_count_d = total;
      cnt_d       = 2'd0;
      acc_data_d  = 8'h00;
      acc_sat_d   = 4'h0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (accept) begin
        cnt_d      = cnt_q + 2'd1;
        acc_data_d = merged_data;
        acc_sat_d  = merged_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      acc_data_q  <= 8'h00;
      acc_sat_q   <= 4'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sat_q   <= 4'h0;
      out_count_q <= 3'd0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_sat_q   <= acc_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_sign_packer.sv
// Bench for sign_packer: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_sign_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_sat;
  logic [2:0] out_count;
  logic       out_ready = 1'b0;

  sign_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_sat(out_sat), .out_count(out_count),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: held samples as plain integers, output as one register.
  int         m_vals[$];
  bit         m_sats[$];
  bit         m_ov;
  logic [7:0] m_od;
  logic [3:0] m_os;
  logic [2:0] m_oc;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       fl;
    logic       ordy;
    logic       e_v;
    logic [7:0] e_d;
    logic [3:0] e_s;
    logic [2:0] e_c;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_vals.delete();
    m_sats.delete();
    m_ov = 1'b0;
    m_od = 8'h00;
    m_os = 4'h0;
    m_oc = 3'd0;
  endtask

  function automatic bit model_in_ready(input logic ordy);
    return (m_vals.size() < 3) || !m_ov || ordy;
  endfunction

  task automatic model_emit();
    int data = 0;
    int sat = 0;
    for (int k = 0; k < m_vals.size(); k++) begin
      data += ((m_vals[k] + 4) % 4) << (2 * k);
      sat  += int'(m_sats[k]) << k;
    end
    m_ov = 1'b1;
    m_od = 8'(data);
    m_os = 4'(sat);
    m_oc = 3'(m_vals.size());
    m_vals.delete();
    m_sats.delete();
  endtask

  task automatic model_step(input logic iv, input logic [7:0] d, input logic fl, input logic ordy);
    bit slot = !m_ov || ordy;
    int v;
    if (iv && model_in_ready(ordy)) begin
      v = $signed(d);
      if (v > 1) begin m_vals.push_back(1); m_sats.push_back(1'b1); end
      else if (v < -2) begin m_vals.push_back(-2); m_sats.push_back(1'b1); end
      else begin m_vals.push_back(v); m_sats.push_back(1'b0); end
    end
    if (m_vals.size() == 4) model_emit();
    else if (fl && slot && m_vals.size() > 0) model_emit();
    else if (ordy) m_ov = 1'b0;
  endtask

  // One clock cycle: drive, check in_ready mid-cycle, clock, check registered outputs.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("in_ready_vs_model", {31'd0, in_ready}, {31'd0, model_in_ready(ordy)});
    model_step(iv, d, fl, ordy);
    @(posedge clk);
    #1;
    checkOutput("out_valid_vs_model", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      checkOutput("out_data_vs_model", {24'd0, out_data}, {24'd0, m_od});
      checkOutput("out_sat_vs_model", {28'd0, out_sat}, {28'd0, m_os});
      checkOutput("out_count_vs_model", {29'd0, out_count}, {29'd0, m_oc});
    end
  endtask

  task automatic expectWord(input string tag, input logic v, input logic [7:0] d,
                            input logic [3:0] s, input logic [2:0] c);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      checkOutput({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
      checkOutput({tag, "_sat"}, {28'd0, out_sat}, {28'd0, s});
      checkOutput({tag, "_count"}, {29'd0, out_count}, {29'd0, c});
    end
  endtask

  task automatic pulseReset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic expectResetState(input string tag);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    checkOutput({tag, "_out_sat"}, {28'd0, out_sat}, 32'd0);
    checkOutput({tag, "_out_count"}, {29'd0, out_count}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t t;
    logic [7:0] rd;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expectResetState("reset");

    // {iv, data, flush, out_ready, exp_valid, exp_data, exp_sat, exp_count}
    vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hE4, 4'h0, 3'd4});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 8'h99, 4'hF, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0D, 4'h0, 3'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0D, 4'h0, 3'd3});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h55, 4'h0, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      applyStimulus(t.iv, t.d, t.fl, t.ordy);
      expectWord($sformatf("vec%0d", i), t.e_v, t.e_d, t.e_s, t.e_c);
    end

    // Backpressure: three samples absorbed behind a stalled word, the eighth waits.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    expectWord("bp_hold", 1'b1, 8'h55, 4'h0, 3'd4);
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    expectWord("bp_stable", 1'b1, 8'h55, 4'h0, 3'd4);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
    expectWord("bp_reload", 1'b1, 8'h55, 4'h0, 3'd4);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    expectWord("bp_drain", 1'b0, 8'h00, 4'h0, 3'd0);

    // Flush held while the slot is busy is honored once the word drains.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectWord("flush_busy", 1'b1, 8'h55, 4'h0, 3'd4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    expectWord("flush_late", 1'b1, 8'h01, 4'h0, 3'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    expectWord("flush_drain", 1'b0, 8'h00, 4'h0, 3'd0);

    // Reset mid-operation drops both the partial and the pending word.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    expectWord("pre_reset", 1'b1, 8'h00, 4'h0, 3'd4);
    pulseReset();
    expectResetState("midreset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    expectWord("post_reset", 1'b1, 8'h00, 4'h0, 3'd4);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(0, 255));
      else rd = 8'($urandom_range(0, 3)) - 8'd2;
      applyStimulus($urandom_range(0, 3) != 0, rd, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
